// File: rtl/odo_pkg.sv
// -----------------------------------------------------------------------------
// odo_pkg
//   Shared widths, defaults and the sequencer state encoding for the Odo round
//   sequencer slice.
//   Contents:
//     ODO_STATE_W         width of the full Odo state (640)
//     ODO_KEY_W           width of one round key (10)
//     ODO_ROUNDS_DEFAULT  default number of full rounds per hash (84)
//     odo_seq_state_t     IDLE / ISSUE / WAIT / DONE controller states
// -----------------------------------------------------------------------------
package odo_pkg;

   localparam int ODO_STATE_W        = 640;
   localparam int ODO_KEY_W          = 10;
   localparam int ODO_ROUNDS_DEFAULT = 84;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } odo_seq_state_t;

endpackage

// File: rtl/odo_round_key_table.sv
// -----------------------------------------------------------------------------
// odo_round_key_table
//   ROUNDS x ODO_KEY_W round-key register file. One synchronous write port and
//   an asynchronous read port indexed by the current round. The write guard
//   lives here: a write is dropped while the sequencer is busy (including the
//   edge on which a new state is accepted) or when key_addr is out of range,
//   and key_err pulses for one cycle after every dropped write.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     wr_block     high while writes must be refused (busy or accepting)
//     key_we       write strobe
//     key_addr     round index to write
//     key_data     key value to write
//     rd_idx       round index to read
//     rd_key       key for rd_idx (combinational)
//     key_err      one-cycle pulse: last write was dropped
// -----------------------------------------------------------------------------
module odo_round_key_table
   import odo_pkg::*;
#(
   parameter int ROUNDS = ODO_ROUNDS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_block,
   input  logic                 key_we,
   input  logic [7:0]           key_addr,
   input  logic [ODO_KEY_W-1:0] key_data,
   input  logic [7:0]           rd_idx,
   output logic [ODO_KEY_W-1:0] rd_key,
   output logic                 key_err
);

   logic [ODO_KEY_W-1:0] keys [ROUNDS];
   logic                 wr_ok;

   assign wr_ok = key_we && !wr_block && (key_addr < 8'(ROUNDS));

   // NOTE: the table is small and its contents are architecturally visible
   // (an unwritten round must use key 0), so every entry takes the reset.
   // NOTE: sequential state is assigned with <= only, so all registers in the
   // block sample their inputs from the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROUNDS; i++) begin
            keys[i] <= '0;
         end
         key_err <= 1'b0;
      end else begin
         for (int i = 0; i < ROUNDS; i++) begin
            if (wr_ok && (key_addr == 8'(i))) begin
               keys[i] <= key_data;
            end
         end
         key_err <= key_we && !wr_ok;
      end
   end

   // NOTE: rd_key gets a default before the loop so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      rd_key = '0;
      for (int i = 0; i < ROUNDS; i++) begin
         if (rd_idx == 8'(i)) begin
            rd_key = keys[i];
         end
      end
   end

endmodule

// File: rtl/odo_round_sequencer.sv
// -----------------------------------------------------------------------------
// odo_round_sequencer
//   Iterative controller for one shared, external odo_full_round datapath.
//   Accepts a 640-bit state on the in_* handshake, applies ROUNDS rounds by
//   cycling the state through the round core (ROUND_LAT+1 cycles per round),
//   and returns the result on the out_* handshake.
//   Parameters:
//     ROUNDS     rounds per hash (2..255)
//     ROUND_LAT  round core latency in cycles (1..7)
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     input handshake, in_data = initial state
//     out_valid/out_ready   output handshake, out_data = final state
//     key_we/key_addr/key_data  round-key table write port
//     key_err               one-cycle pulse on a dropped key write
//     rnd_in/rnd_key        state and round key to the round core
//     rnd_out               round core result
//     busy                  high from accept until the out handshake
//     perf_hashes           (ODO_SEQ_PERF_EN) completed hashes, wrapping
//     perf_stall            (ODO_SEQ_PERF_EN) DONE cycles without out_ready,
//                           saturating
//   Configuration macro: ODO_SEQ_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module odo_round_sequencer
   import odo_pkg::*;
#(
   parameter int ROUNDS    = ODO_ROUNDS_DEFAULT,
   parameter int ROUND_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ODO_STATE_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ODO_STATE_W-1:0] out_data,
   input  logic                   key_we,
   input  logic [7:0]             key_addr,
   input  logic [ODO_KEY_W-1:0]   key_data,
   output logic                   key_err,
   output logic [ODO_STATE_W-1:0] rnd_in,
   output logic [ODO_KEY_W-1:0]   rnd_key,
   input  logic [ODO_STATE_W-1:0] rnd_out,
   output logic                   busy
`ifdef ODO_SEQ_PERF_EN
   ,
   output logic [31:0]            perf_hashes,
   output logic [31:0]            perf_stall
`endif
);

   localparam logic [7:0] R_LAST   = 8'(ROUNDS - 1);
   localparam logic [2:0] LAT_LAST = 3'(ROUND_LAT - 1);

   odo_seq_state_t         fsm;
   logic [7:0]             r;
   logic [2:0]             lat;
   logic [ODO_STATE_W-1:0] st;
   logic                   accept;

   // Handshake flags decode the state register only, never in_valid, so
   // in_ready cannot combinationally depend on the upstream.
   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm != IDLE);
   assign accept    = in_valid && in_ready;

   // The state register feeds the round core directly; it only changes on the
   // last WAIT edge of a round, so rnd_in is stable for the whole round.
   assign rnd_in   = st;
   assign out_data = st;

   // A write on the accepting edge is treated as busy, so a hash never sees a
   // key table that changed under it.
   odo_round_key_table #(
      .ROUNDS (ROUNDS)
   ) u_key_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_block (busy || accept),
      .key_we   (key_we),
      .key_addr (key_addr),
      .key_data (key_data),
      .rd_idx   (r),
      .rd_key   (rnd_key),
      .key_err  (key_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm <= IDLE;
         r   <= '0;
         lat <= '0;
         st  <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (accept) begin
                  st  <= in_data;
                  r   <= '0;
                  fsm <= ISSUE;
               end
            end
            ISSUE: begin
               lat <= '0;
               fsm <= WAIT;
            end
            WAIT: begin
               if (lat == LAT_LAST) begin
                  st <= rnd_out;
                  if (r == R_LAST) begin
                     fsm <= DONE;
                  end else begin
                     r   <= r + 8'd1;
                     fsm <= ISSUE;
                  end
               end else begin
                  lat <= lat + 3'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

`ifdef ODO_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hashes <= '0;
         perf_stall  <= '0;
      end else begin
         if (out_valid && out_ready) begin
            perf_hashes <= perf_hashes + 32'd1;
         end
         if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_odo_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_odo_round_sequencer
//   Directed bench for odo_round_sequencer with ROUNDS=4, ROUND_LAT=1 and a
//   one-cycle behavioural round core: out = rotl(in,1) ^ {630'b0, key}.
//   Expected results are hand-computed constants:
//     in=1,      keys 1,2,3,4 : 1 -> 3 -> 4 -> b -> 12
//     in=1<<639, keys 1,2,3,4 : 1<<639 -> 0 -> 2 -> 7 -> a
//     in=1,      keys 1,2,3,5 : 1 -> 3 -> 4 -> b -> 13
//   With ODO_SEQ_PERF_EN defined the performance counters are checked too.
// -----------------------------------------------------------------------------
module tb_odo_round_sequencer;
   import odo_pkg::*;

   localparam int ROUNDS    = 4;
   localparam int ROUND_LAT = 1;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [ODO_STATE_W-1:0] in_data = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [ODO_STATE_W-1:0] out_data;
   logic                   key_we = 1'b0;
   logic [7:0]             key_addr = '0;
   logic [ODO_KEY_W-1:0]   key_data = '0;
   logic                   key_err;
   logic [ODO_STATE_W-1:0] rnd_in;
   logic [ODO_KEY_W-1:0]   rnd_key;
   logic [ODO_STATE_W-1:0] rnd_out = '0;
   logic                   busy;
`ifdef ODO_SEQ_PERF_EN
   logic [31:0]            perf_hashes;
   logic [31:0]            perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   odo_round_sequencer #(
      .ROUNDS    (ROUNDS),
      .ROUND_LAT (ROUND_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .key_we    (key_we),
      .key_addr  (key_addr),
      .key_data  (key_data),
      .key_err   (key_err),
      .rnd_in    (rnd_in),
      .rnd_key   (rnd_key),
      .rnd_out   (rnd_out),
      .busy      (busy)
`ifdef ODO_SEQ_PERF_EN
      ,
      .perf_hashes (perf_hashes),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle behavioural round core.
   always @(posedge clk) begin
      rnd_out <= {rnd_in[ODO_STATE_W-2:0], rnd_in[ODO_STATE_W-1]}
                 ^ {{(ODO_STATE_W-ODO_KEY_W){1'b0}}, rnd_key};
   end

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (rnd_in !== '0) begin
         errors++; $display("FAIL reset_rnd_in got %h want 0", rnd_in);
      end
      checks++;
      if (rnd_key !== '0 || key_err !== 1'b0) begin
         errors++; $display("FAIL reset_key got key=%h err=%b want 0 0", rnd_key, key_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL idle_after_release got busy=%b in_ready=%b want 0 1", busy, in_ready);
      end
   endtask

   task automatic test_basic_hash();
      for (int i = 0; i < ROUNDS; i++) begin
         key_we   = 1'b1;
         key_addr = 8'(i);
         key_data = 10'(i + 1);
         step();
         checks++;
         if (key_err !== 1'b0) begin
            errors++; $display("FAIL key_load_err[%0d] got %b want 0", i, key_err);
         end
      end
      key_we    = 1'b0;
      out_ready = 1'b0;
      in_data   = 640'h1;
      in_valid  = 1'b1;
      step();  // accepting edge
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL accept_busy got busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) step();
         checks++;
         if (out_valid !== (c == 8 ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL out_valid_timing cycle %0d got %b want %b", c, out_valid, (c == 8));
         end
         if (c < 8) begin
            checks++;
            if (rnd_key !== 10'(c / 2 + 1)) begin
               errors++; $display("FAIL rnd_key_step cycle %0d got %0h want %0h", c, rnd_key, c / 2 + 1);
            end
         end
      end
      checks++;
      if (out_data !== 640'h12) begin
         errors++; $display("FAIL basic_result got %h want 12", out_data);
      end
   endtask

   task automatic test_backpressure();
      // DONE from the previous task, out_ready still low; a competing input
      // must be ignored until the sequencer returns to IDLE.
      in_data  = {1'b1, 639'b0};
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 640'h12) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got valid=%b in_ready=%b data=%h want 1 0 12",
                     c, out_valid, in_ready, out_data);
         end
      end
      out_ready = 1'b1;
      step();  // out handshake edge, no accept here
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release got in_ready=%b valid=%b busy=%b want 1 0 0",
                            in_ready, out_valid, busy);
      end
      step();  // accepting edge for the second hash
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL second_accept got busy=%b want 1", busy);
      end
      repeat (7) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL second_early got out_valid=%b want 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 640'ha) begin
         errors++; $display("FAIL second_result got valid=%b data=%h want 1 a", out_valid, out_data);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_key_writes();
      in_data  = 640'h1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      key_we   = 1'b1;
      key_addr = 8'd0;
      key_data = 10'h3ff;
      step();
      key_we = 1'b0;
      checks++;
      if (key_err !== 1'b1) begin
         errors++; $display("FAIL key_busy_err got %b want 1", key_err);
      end
      step();
      checks++;
      if (key_err !== 1'b0) begin
         errors++; $display("FAIL key_err_pulse got %b want 0", key_err);
      end
      for (int c = 0; c < 20 && out_valid !== 1'b1; c++) step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 640'h12) begin
         errors++; $display("FAIL busy_write_dropped got valid=%b data=%h want 1 12", out_valid, out_data);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      key_we   = 1'b1;
      key_addr = 8'd4;
      key_data = 10'h7;
      step();
      checks++;
      if (key_err !== 1'b1) begin
         errors++; $display("FAIL key_range_err got %b want 1", key_err);
      end
      key_addr = 8'd3;
      key_data = 10'h5;
      step();
      key_we = 1'b0;
      checks++;
      if (key_err !== 1'b0) begin
         errors++; $display("FAIL key_write_ok got %b want 0", key_err);
      end

      // Write coincident with the accepting edge must be dropped.
      in_data  = 640'h1;
      in_valid = 1'b1;
      key_we   = 1'b1;
      key_addr = 8'd0;
      key_data = 10'h3ff;
      step();
      in_valid = 1'b0;
      key_we   = 1'b0;
      checks++;
      if (key_err !== 1'b1) begin
         errors++; $display("FAIL key_accept_err got %b want 1", key_err);
      end
      for (int c = 0; c < 20 && out_valid !== 1'b1; c++) step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 640'h13) begin
         errors++; $display("FAIL new_key_used got valid=%b data=%h want 1 13", out_valid, out_data);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_hash();
      logic seen;
      in_data  = 640'h1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();  // ISSUE of round index 2
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_flags got in_ready=%b valid=%b busy=%b want 1 0 0",
                            in_ready, out_valid, busy);
      end
      checks++;
      if (rnd_in !== '0 || rnd_key !== '0 || key_err !== 1'b0) begin
         errors++; $display("FAIL mid_reset_rnd got rnd_in=%h key=%h err=%b want 0 0 0",
                            rnd_in, rnd_key, key_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         step();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL no_out_after_reset got out_valid seen=%b want 0", seen);
      end
   endtask

`ifdef ODO_SEQ_PERF_EN
   task automatic run_hash(input int stalls);
      in_data  = 640'h5;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 20 && out_valid !== 1'b1; c++) step();
      repeat (stalls) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_perf();
      checks++;
      if (perf_hashes !== 32'd0 || perf_stall !== 32'd0) begin
         errors++; $display("FAIL perf_reset got hashes=%0d stall=%0d want 0 0", perf_hashes, perf_stall);
      end
      run_hash(0);
      run_hash(2);
      run_hash(0);
      checks++;
      if (perf_hashes !== 32'd3 || perf_stall !== 32'd2) begin
         errors++; $display("FAIL perf_counts got hashes=%0d stall=%0d want 3 2", perf_hashes, perf_stall);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (perf_hashes !== 32'd0 || perf_stall !== 32'd0) begin
         errors++; $display("FAIL perf_rereset got hashes=%0d stall=%0d want 0 0", perf_hashes, perf_stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic_hash();
      test_backpressure();
      test_key_writes();
      test_reset_mid_hash();
`ifdef ODO_SEQ_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
